// File: rtl/rx_pkt_fifo_pkg.sv
// Shared types and helpers for the packet-aware receive FIFO.
// Default depth, FSM state encoding and pointer width calculation.

package rx_pkt_fifo_pkg;

  localparam int unsigned DefaultDepth = 16;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StDrop,
    StCommit,
    StRewind
  } rx_state_e;

  // One extra bit on top of the address distinguishes full from empty.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/rx_pkt_fifo_ram.sv
// Byte storage for rx_pkt_fifo: Depth x 9 bits (data plus end-of-packet flag).
// Synchronous write and flag-set ports, asynchronous read port.

module rx_pkt_fifo_ram #(
  parameter int unsigned Depth = 16,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [7:0]       wdata_i,
  input  logic             fset_i,
  input  logic [AddrW-1:0] faddr_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [8:0]       rdata_o
);

  logic [8:0] mem_q [Depth];

  // A fresh write always clears the flag; the flag is only set on commit.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= {1'b0, wdata_i};
    end
    if (fset_i) begin
      mem_q[faddr_i][8] <= 1'b1;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/rx_pkt_fifo.sv
// Packet-aware receive FIFO: bytes become readable only once their packet ends cleanly.
// Optional feature: define RX_PKT_FIFO_STATS_EN to add the drop_count output.

module rx_pkt_fifo
  import rx_pkt_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = DefaultDepth,
  parameter int unsigned PtrW  = ptr_width(DEPTH)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            w_enable,
  input  logic [7:0]      rcv_data,
  input  logic            rcving,
  input  logic            r_error,
  input  logic            r_enable,
  output logic [7:0]      rx_data,
  output logic            rx_last,
  output logic            empty,
  output logic            full,
  output logic [PtrW-1:0] pkt_avail,
  output logic            overrun
`ifdef RX_PKT_FIFO_STATS_EN
  ,
  output logic [7:0]      drop_count
`endif
);

  localparam int unsigned AddrW = PtrW - 1;

  rx_state_e state_q, state_d;

  logic [PtrW-1:0] rd_q, rd_d;
  logic [PtrW-1:0] cm_q, cm_d;
  logic [PtrW-1:0] sp_q, sp_d;
  logic [PtrW-1:0] pkt_q, pkt_d;
  logic            overrun_q, overrun_d;
  logic            armed_q, armed_d;

  logic            wr_en;
  logic            commit_en;
  logic            rewind_en;
  logic            ovf_set;
  logic            rd_pop;
  logic            pop_last;
  logic [PtrW-1:0] occupancy;
  logic [PtrW-1:0] sp_last;
  logic [8:0]      ram_rdata;
  logic            pkt_err;

  assign occupancy = sp_q - rd_q;
  assign sp_last   = sp_q - PtrW'(1);
  assign full      = (occupancy == PtrW'(DEPTH));
  assign empty     = (rd_q == cm_q);
  assign pkt_err   = rcving && r_error;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state; armed_q blocks capture of a packet already in flight at reset
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (rcving && armed_q) begin
          state_d = StRecv;
        end
      end
      StRecv: begin
        if (pkt_err || (w_enable && full)) begin
          state_d = StDrop;
        end else if (!rcving) begin
          state_d = StCommit;
        end
      end
      StDrop: begin
        if (!rcving) begin
          state_d = StRewind;
        end
      end
      StCommit: state_d = StIdle;
      StRewind: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    wr_en     = 1'b0;
    commit_en = 1'b0;
    rewind_en = 1'b0;
    ovf_set   = 1'b0;
    unique case (state_q)
      StRecv: begin
        if (!pkt_err && w_enable) begin
          if (full) begin
            ovf_set = 1'b1;
          end else begin
            wr_en = 1'b1;
          end
        end
      end
      StCommit: commit_en = (sp_q != cm_q);
      StRewind: rewind_en = 1'b1;
      default: ;
    endcase
  end

  assign rd_pop   = r_enable && !empty;
  assign pop_last = rd_pop && ram_rdata[8];

  always_comb begin
    sp_d = sp_q;
    if ((state_q == StIdle) || rewind_en) begin
      sp_d = cm_q;
    end else if (wr_en) begin
      sp_d = sp_q + PtrW'(1);
    end
  end

  assign cm_d      = commit_en ? sp_q : cm_q;
  assign rd_d      = rd_pop ? (rd_q + PtrW'(1)) : rd_q;
  assign overrun_d = overrun_q | ovf_set;
  assign armed_d   = armed_q | !rcving;

  // A commit and a last-byte pop in the same cycle cancel out.
  always_comb begin
    pkt_d = pkt_q;
    if (commit_en && !pop_last) begin
      pkt_d = pkt_q + PtrW'(1);
    end else if (!commit_en && pop_last) begin
      pkt_d = pkt_q - PtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q      <= '0;
      cm_q      <= '0;
      sp_q      <= '0;
      pkt_q     <= '0;
      overrun_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      rd_q      <= rd_d;
      cm_q      <= cm_d;
      sp_q      <= sp_d;
      pkt_q     <= pkt_d;
      overrun_q <= overrun_d;
      armed_q   <= armed_d;
    end
  end

  rx_pkt_fifo_ram #(
    .Depth (DEPTH),
    .AddrW (AddrW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (sp_q[AddrW-1:0]),
    .wdata_i (rcv_data),
    .fset_i  (commit_en),
    .faddr_i (sp_last[AddrW-1:0]),
    .raddr_i (rd_q[AddrW-1:0]),
    .rdata_o (ram_rdata)
  );

  assign rx_data   = empty ? 8'h00 : ram_rdata[7:0];
  assign rx_last   = empty ? 1'b0 : ram_rdata[8];
  assign pkt_avail = pkt_q;
  assign overrun   = overrun_q;

`ifdef RX_PKT_FIFO_STATS_EN
  logic [7:0] drop_q, drop_d;

  always_comb begin
    drop_d = drop_q;
    if (rewind_en && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= 8'h00;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_count = drop_q;
`endif

endmodule

// File: tb/tb_rx_pkt_fifo.sv
// Self-checking bench for rx_pkt_fifo: scoreboard of committed bytes, one task per scenario.
// Checks drop_count only when RX_PKT_FIFO_STATS_EN is defined.

module tb_rx_pkt_fifo;

  localparam int unsigned Depth = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       w_enable;
  logic [7:0] rcv_data;
  logic       rcving;
  logic       r_error;
  logic       r_enable;
  logic [7:0] rx_data;
  logic       rx_last;
  logic       empty;
  logic       full;
  logic [4:0] pkt_avail;
  logic       overrun;
`ifdef RX_PKT_FIFO_STATS_EN
  logic [7:0] drop_count;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [8:0] sb_q[$];
  logic [8:0] pend_q[$];

  always #5 clk = ~clk;

  rx_pkt_fifo #(
    .DEPTH (Depth)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .w_enable   (w_enable),
    .rcv_data   (rcv_data),
    .rcving     (rcving),
    .r_error    (r_error),
    .r_enable   (r_enable),
    .rx_data    (rx_data),
    .rx_last    (rx_last),
    .empty      (empty),
    .full       (full),
    .pkt_avail  (pkt_avail),
    .overrun    (overrun)
`ifdef RX_PKT_FIFO_STATS_EN
    ,
    .drop_count (drop_count)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pkt();
    rcving = 1'b1;
    step();
  endtask

  task automatic write_byte(input logic [7:0] b);
    w_enable = 1'b1;
    rcv_data = b;
    step();
    w_enable = 1'b0;
    pend_q.push_back({1'b0, b});
  endtask

  // Drop rcving, wait through COMMIT, then move the packet into the scoreboard.
  task automatic end_clean();
    logic [8:0] tmp;
    rcving = 1'b0;
    step();
    step();
    while (pend_q.size() > 0) begin
      tmp = pend_q.pop_front();
      if (pend_q.size() == 0) tmp[8] = 1'b1;
      sb_q.push_back(tmp);
    end
  endtask

  task automatic pop_check(input string name);
    logic [8:0] exp;
    vectors++;
    if (sb_q.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard underflow, actual {last,data}=%b_%h", name, rx_last, rx_data);
    end else begin
      exp = sb_q.pop_front();
      if ({rx_last, rx_data} !== exp) begin
        miscompares++;
        $display("FAIL %s: actual last=%b data=%h, required last=%b data=%h",
                 name, rx_last, rx_data, exp[8], exp[7:0]);
      end
    end
    r_enable = 1'b1;
    step();
    r_enable = 1'b0;
  endtask

  task automatic check_state(input string name, input logic exp_empty, input logic exp_full,
                             input logic [4:0] exp_pkt, input logic exp_ovr);
    vectors++;
    if ({empty, full, pkt_avail, overrun} !== {exp_empty, exp_full, exp_pkt, exp_ovr}) begin
      miscompares++;
      $display("FAIL %s: actual empty=%b full=%b pkt_avail=%0d overrun=%b, required %b %b %0d %b",
               name, empty, full, pkt_avail, overrun, exp_empty, exp_full, exp_pkt, exp_ovr);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    check_state("reset_flags", 1'b1, 1'b0, 5'd0, 1'b0);
    vectors++;
    if ({rx_last, rx_data} !== 9'h000) begin
      miscompares++;
      $display("FAIL reset_head: actual last=%b data=%h, required 0 00", rx_last, rx_data);
    end
`ifdef RX_PKT_FIFO_STATS_EN
    vectors++;
    if (drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_drop_count: actual %0d, required 0", drop_count);
    end
`endif
    step();
  endtask

  task automatic test_clean_packet();
    start_pkt();
    write_byte(8'hA5);
    write_byte(8'h3C);
    write_byte(8'h7E);
    rcving = 1'b0;
    step();
    check_state("clean_commit_pending", 1'b1, 1'b0, 5'd0, 1'b0);
    step();
    sb_q.push_back(9'h0A5);
    sb_q.push_back(9'h03C);
    sb_q.push_back(9'h17E);
    pend_q.delete();
    check_state("clean_committed", 1'b0, 1'b0, 5'd1, 1'b0);
    vectors++;
    if (rx_data !== 8'hA5) begin
      miscompares++;
      $display("FAIL clean_head: actual %h, required a5", rx_data);
    end
    for (int i = 0; i < 3; i++) pop_check("clean_pop");
    check_state("clean_drained", 1'b1, 1'b0, 5'd0, 1'b0);
    // Pop while empty must be ignored.
    r_enable = 1'b1;
    step();
    r_enable = 1'b0;
    check_state("empty_pop_ignored", 1'b1, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic test_error_packet();
    start_pkt();
    write_byte(8'h11);
    write_byte(8'h22);
    r_error = 1'b1;
    step();
    r_error = 1'b0;
    rcving = 1'b0;
    step();
    step();
    pend_q.delete();
    check_state("error_dropped", 1'b1, 1'b0, 5'd0, 1'b0);
`ifdef RX_PKT_FIFO_STATS_EN
    vectors++;
    if (drop_count !== 8'd1) begin
      miscompares++;
      $display("FAIL error_drop_count: actual %0d, required 1", drop_count);
    end
`endif
  endtask

  task automatic test_overflow();
    start_pkt();
    for (int i = 0; i < 16; i++) write_byte(8'(8'h40 + i));
    check_state("overflow_full", 1'b1, 1'b1, 5'd0, 1'b0);
    write_byte(8'hEE);
    check_state("overflow_sticky", 1'b1, 1'b1, 5'd0, 1'b1);
    rcving = 1'b0;
    step();
    step();
    pend_q.delete();
    check_state("overflow_rewound", 1'b1, 1'b0, 5'd0, 1'b1);
`ifdef RX_PKT_FIFO_STATS_EN
    vectors++;
    if (drop_count !== 8'd2) begin
      miscompares++;
      $display("FAIL overflow_drop_count: actual %0d, required 2", drop_count);
    end
`endif
    start_pkt();
    write_byte(8'h01);
    write_byte(8'h02);
    write_byte(8'h03);
    write_byte(8'h04);
    end_clean();
    check_state("after_overflow_commit", 1'b0, 1'b0, 5'd1, 1'b1);
    for (int i = 0; i < 4; i++) pop_check("after_overflow_pop");
  endtask

  task automatic test_back_to_back();
    start_pkt();
    write_byte(8'hB1);
    write_byte(8'hB2);
    write_byte(8'hB3);
    end_clean();
    start_pkt();
    write_byte(8'hC1);
    write_byte(8'hC2);
    end_clean();
    check_state("b2b_two_pkts", 1'b0, 1'b0, 5'd2, 1'b1);
    for (int i = 0; i < 5; i++) pop_check("b2b_pop");
    check_state("b2b_drained", 1'b1, 1'b0, 5'd0, 1'b1);
  endtask

  task automatic test_wrap();
    logic saw_full;
    for (int p = 0; p < 10; p++) begin
      saw_full = 1'b0;
      start_pkt();
      for (int i = 0; i < 5; i++) begin
        write_byte(8'($urandom_range(255)));
        saw_full |= full;
      end
      end_clean();
      saw_full |= full;
      for (int i = 0; i < 5; i++) pop_check("wrap_pop");
      vectors++;
      if (saw_full !== 1'b0) begin
        miscompares++;
        $display("FAIL wrap_full: actual full seen=%b, required 0 (packet %0d)", saw_full, p);
      end
    end
  endtask

  task automatic test_commit_pop_same_cycle();
    logic [8:0] exp;
    logic [8:0] tmp;
    start_pkt();
    write_byte(8'h51);
    write_byte(8'h52);
    end_clean();
    pop_check("same_cycle_first");
    start_pkt();
    write_byte(8'h61);
    write_byte(8'h62);
    rcving = 1'b0;
    step();
    // FSM is in COMMIT now; pop the last byte of the previous packet on the same edge.
    exp = sb_q.pop_front();
    vectors++;
    if ({rx_last, rx_data} !== exp) begin
      miscompares++;
      $display("FAIL same_cycle_head: actual last=%b data=%h, required last=%b data=%h",
               rx_last, rx_data, exp[8], exp[7:0]);
    end
    r_enable = 1'b1;
    step();
    r_enable = 1'b0;
    while (pend_q.size() > 0) begin
      tmp = pend_q.pop_front();
      if (pend_q.size() == 0) tmp[8] = 1'b1;
      sb_q.push_back(tmp);
    end
    check_state("same_cycle_pkt_avail", 1'b0, 1'b0, 5'd1, 1'b1);
    pop_check("same_cycle_drain");
    pop_check("same_cycle_drain");
    check_state("same_cycle_drained", 1'b1, 1'b0, 5'd0, 1'b1);
  endtask

  task automatic test_reset_mid_packet();
    start_pkt();
    write_byte(8'h91);
    write_byte(8'h92);
    rst = 1'b1;
    step();
    rst = 1'b0;
    pend_q.delete();
    check_state("midreset_flags", 1'b1, 1'b0, 5'd0, 1'b0);
    vectors++;
    if ({rx_last, rx_data} !== 9'h000) begin
      miscompares++;
      $display("FAIL midreset_head: actual last=%b data=%h, required 0 00", rx_last, rx_data);
    end
`ifdef RX_PKT_FIFO_STATS_EN
    vectors++;
    if (drop_count !== 8'd0) begin
      miscompares++;
      $display("FAIL midreset_drop_count: actual %0d, required 0", drop_count);
    end
`endif
    // Remainder of the interrupted packet must not be captured.
    write_byte(8'h93);
    write_byte(8'h94);
    rcving = 1'b0;
    step();
    step();
    pend_q.delete();
    check_state("midreset_tail_ignored", 1'b1, 1'b0, 5'd0, 1'b0);
    start_pkt();
    write_byte(8'hD1);
    write_byte(8'hD2);
    write_byte(8'hD3);
    end_clean();
    check_state("midreset_fresh_commit", 1'b0, 1'b0, 5'd1, 1'b0);
    for (int i = 0; i < 3; i++) pop_check("midreset_fresh_pop");
  endtask

  initial begin
    rst      = 1'b0;
    w_enable = 1'b0;
    rcv_data = 8'h00;
    rcving   = 1'b0;
    r_error  = 1'b0;
    r_enable = 1'b0;
    test_reset();
    test_clean_packet();
    test_error_packet();
    test_overflow();
    test_back_to_back();
    test_wrap();
    test_commit_pop_same_cycle();
    test_reset_mid_packet();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
